pkt_tx_buf: RTL and testbench
=============================

Name: pkt_tx_buf

Overview:
Transmit-side packet buffer for the eBPF softcore. It receives the program's packet stores (eBPF ST/STX of byte, half-word, word and double-word) into a 128-byte packet image. On command, it streams the first tx_len bytes out as 64-bit beats over a valid/ready interface with last/keep. It sits between the core's store path and the egress stream, mirroring the receive-side packet buffer that loads packets and serves loads.

Parameters:
PKT_BYTES, 128, packet image size in bytes; multiple of 8, max 255
BEAT_BYTES, 8, bytes per output beat; fixed, tx_data width = 64

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
wr_en  in  1  store request, one store per cycle
wr_off  in  64  byte offset of store (src/dst + imm)
wr_size  in  2  00 b, 01 hw, 10 w, 11 dw
wr_data  in  64  store data; low-order bytes used
wr_err  out  1  one-cycle pulse: store rejected
tx_start  in  1  begin transmission (IDLE only)
tx_len  in  8  packet length in bytes, sampled with tx_start
tx_data  out  64  beat data
tx_keep  out  8  byte-valid mask for beat
tx_valid  out  1  beat valid
tx_ready  in  1  sink accepts beat
tx_last  out  1  final beat of packet
busy  out  1  high while in SEND
tx_done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Storage: PKT_BYTES bytes, little-endian. Byte i is packet byte i, and beat k carries bytes 8k..8k+7 with byte 8k in tx_data[7:0].
- Reset: all bytes 0. FSM to IDLE. tx_valid, tx_last, busy, tx_done, wr_err = 0. tx_keep = 0. tx_data = 0.
- Stores: n = 1/2/4/8 for wr_size.
  - Accepted when wr_en, FSM = IDLE, and wr_off + n <= PKT_BYTES. The range test is full 64-bit unsigned with no wrap.
  - Bytes wr_off..wr_off+n-1 take wr_data[8n-1:0], written at the clock edge. Other bytes are unchanged. No alignment requirement.
  - Rejected when out of range or when FSM = SEND. Memory is unchanged and wr_err pulses high the next cycle for one cycle.
- FSM states: IDLE, SEND.
  - IDLE, on tx_start:
    - Latch L = min(tx_len, PKT_BYTES).
    - If L = 0: stay IDLE and pulse tx_done next cycle.
    - Else: beats B = ceil(L/8), idx = 0, go to SEND.
    - tx_valid rises the cycle after tx_start (latency 1).
  - IDLE, simultaneous wr_en and tx_start: the store is applied at the same edge, and the transmitted data includes it.
  - SEND outputs:
    - tx_valid = 1, busy = 1, tx_data = beat idx.
    - tx_last = (idx == B-1).
    - tx_keep = 8'hFF except on the last beat, where it is the low (L mod 8) bits set (8'hFF if L mod 8 = 0).
  - SEND, on tx_valid & tx_ready:
    - Not last: idx++.
    - Last: go to IDLE. tx_valid/busy drop next cycle and tx_done pulses that same next cycle.
  - While tx_valid & !tx_ready, tx_data/tx_keep/tx_last hold stable.
  - tx_start during SEND is ignored.
- Throughput: one beat per cycle while tx_ready is held high. Back-to-back packets: tx_start is accepted in the cycle tx_done is high.
- Outputs are registered (tx_data from the registered idx and frozen memory); there is no combinational path from tx_ready to tx_data.
- Reset mid-SEND: transfer aborted, no tx_done, memory cleared, tx_valid low the cycle after the reset edge.
- Bytes beyond L within the last beat still appear on tx_data; the sink must honour tx_keep.

Test Plan:
1. Reset, store dw 64'h0807060504030201 at off 0 and b 8'hAA at off 8, then tx_start len 9, tx_ready=1 -> beat0 data 64'h0807060504030201 keep FF last 0; beat1 data[7:0]=AA keep 01 last 1; tx_done next cycle.
2. tx_len 13 with tx_ready toggled 1,0,0,1 -> beat1 held stable for 2 stalled cycles; keep 8'h1F; exactly 2 handshakes.
3. Store dw at off 121 and hw at off 64'hFFFF_FFFF_FFFF_FFFF -> wr_err pulses each time; a following 128-byte send shows unchanged bytes (all 0 after reset).
4. Store during SEND (w at off 0 = 32'hDEADBEEF) -> wr_err pulse; the data sent is unchanged; a later send shows old contents.
5. tx_len 0 -> no tx_valid, tx_done one cycle later. tx_len 200 -> 16 beats, last keep FF.
6. rst asserted after beat 3 of a 128-byte send -> tx_valid 0 next cycle, no tx_done; a subsequent send shows all-zero data.

Source files
------------

// File: rtl/pkt_tx_buf.sv
// Transmit packet buffer: byte-addressed stores build a packet image, which is
// then streamed out as little-endian 64-bit beats with keep/last.
module pkt_tx_buf #(
    parameter int PKT_BYTES  = 128,
    parameter int BEAT_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [63:0] wr_off,
    input  logic [1:0]  wr_size,
    input  logic [63:0] wr_data,
    output logic        wr_err,
    input  logic        tx_start,
    input  logic [7:0]  tx_len,
    output logic [63:0] tx_data,
    output logic [7:0]  tx_keep,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        busy,
    output logic        tx_done
);
    localparam int NBEATS = PKT_BYTES / BEAT_BYTES;
    localparam int IW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [7:0] MAX_LEN = 8'(PKT_BYTES);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [7:0]      len_reg, len_next;
    logic            done_reg, done_next;
    logic            err_reg;

    logic [PKT_BYTES*8-1:0] img;
    logic [3:0]      wr_n;
    logic            wr_ok;
    logic [7:0]      start_len;
    logic            is_last;
    logic [7:0]      last_keep;

    always_comb begin
        case (wr_size)
            2'd0:    wr_n = 4'd1;
            2'd1:    wr_n = 4'd2;
            2'd2:    wr_n = 4'd4;
            default: wr_n = 4'd8;
        endcase
    end

    // Range test rearranged as off <= SIZE - n so the 64-bit sum can never wrap.
    assign wr_ok = wr_en && (state_reg == IDLE) &&
                   (wr_off <= (64'(PKT_BYTES) - {60'd0, wr_n}));

    assign start_len = (tx_len > MAX_LEN) ? MAX_LEN : tx_len;
    assign is_last   = (idx_reg == IW'((len_reg - 8'd1) >> 3));
    assign last_keep = (len_reg[2:0] == 3'd0) ? 8'hFF : ~(8'hFF << len_reg[2:0]);

    // One register per packet byte; rel is this byte's position inside the store.
    genvar gi;
    generate
        for (gi = 0; gi < PKT_BYTES; gi++) begin : g_byte
            logic [7:0] byte_reg;
            logic [7:0] rel;
            logic       hit;
            assign rel = 8'(gi) - wr_off[7:0];
            assign hit = wr_ok && (rel < {4'd0, wr_n});
            always_ff @(posedge clk) begin
                if (rst)
                    byte_reg <= 8'd0;
                else if (hit)
                    byte_reg <= wr_data[{rel[2:0], 3'b000} +: 8];
            end
            assign img[gi*8 +: 8] = byte_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            len_reg   <= 8'd0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            len_reg   <= len_next;
            done_reg  <= done_next;
            err_reg   <= wr_en && !wr_ok;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        len_next   = len_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (tx_start) begin
                    len_next = start_len;
                    idx_next = '0;
                    if (start_len == 8'd0)
                        done_next = 1'b1;
                    else
                        state_next = SEND;
                end
            end
            default: begin
                if (tx_ready) begin
                    if (is_last) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
        endcase
    end

    // Memory is frozen during SEND, so the beat mux depends only on registers.
    always_comb begin
        tx_valid = 1'b0;
        busy     = 1'b0;
        tx_last  = 1'b0;
        tx_keep  = 8'h00;
        tx_data  = 64'd0;
        if (state_reg == SEND) begin
            tx_valid = 1'b1;
            busy     = 1'b1;
            tx_last  = is_last;
            tx_keep  = is_last ? last_keep : 8'hFF;
            tx_data  = img[{idx_reg, 6'b000000} +: 64];
        end
    end

    assign tx_done = done_reg;
    assign wr_err  = err_reg;
endmodule

// File: tb/tb_pkt_tx_buf.sv
// Scoreboard bench for pkt_tx_buf: a byte-array model predicts beats, store
// errors and done pulses; a negedge monitor pops and compares them.
module tb_pkt_tx_buf;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [63:0] wr_off = 64'd0;
    logic [1:0]  wr_size = 2'd0;
    logic [63:0] wr_data = 64'd0;
    logic        wr_err;
    logic        tx_start = 1'b0;
    logic [7:0]  tx_len = 8'd0;
    logic [63:0] tx_data;
    logic [7:0]  tx_keep;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        tx_last;
    logic        busy;
    logic        tx_done;

    pkt_tx_buf #(.PKT_BYTES(128), .BEAT_BYTES(8)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_off(wr_off), .wr_size(wr_size), .wr_data(wr_data),
        .wr_err(wr_err),
        .tx_start(tx_start), .tx_len(tx_len),
        .tx_data(tx_data), .tx_keep(tx_keep), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    beat_t      exp_q[$];
    bit         err_q[$];
    bit         done_q[$];
    logic [7:0] model [0:127];
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event seen with nothing expected", name);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int i = 0; i < 128; i++) model[i] = 8'd0;
        exp_q.delete();
        err_q.delete();
        done_q.delete();
    endtask

    // Applies a store to the model if legal, otherwise expects an error pulse.
    function automatic bit model_store(input logic [63:0] off, input logic [1:0] size,
                                       input logic [63:0] data, input bit idle);
        int n;
        n = 1 << size;
        if (idle && off <= 64'(128 - n)) begin
            for (int i = 0; i < n; i++) model[int'(off) + i] = data[8*i +: 8];
            return 1'b1;
        end
        err_q.push_back(1'b1);
        return 1'b0;
    endfunction

    // Monitor: compares every handshake, error pulse, done pulse and stall hold.
    bit    prev_stall = 1'b0;
    beat_t prev_b;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, prev_b.data);
                check("stall_keep", tx_keep, prev_b.keep);
                check("stall_last", tx_last, prev_b.last);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) fail_now("spurious_beat");
                else begin
                    e = exp_q.pop_front();
                    check("beat_data", tx_data, e.data);
                    check("beat_keep", tx_keep, e.keep);
                    check("beat_last", tx_last, e.last);
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_b.data = tx_data;
            prev_b.keep = tx_keep;
            prev_b.last = tx_last;
            if (wr_err) begin
                if (err_q.size() == 0) fail_now("spurious_wr_err");
                else void'(err_q.pop_front());
            end
            if (tx_done) begin
                if (done_q.size() == 0) fail_now("spurious_tx_done");
                else void'(done_q.pop_front());
            end
        end
    end

    task automatic do_reset;
        rst = 1'b1;
        step;
        model_clear();
        check("rst_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", wr_err, 0);
        check("rst_keep", tx_keep, 0);
        check("rst_data", tx_data, 0);
        check("rst_last", tx_last, 0);
        rst = 1'b0;
    endtask

    task automatic store(input logic [63:0] off, input logic [1:0] size, input logic [63:0] data);
        bit ok;
        wr_en = 1'b1; wr_off = off; wr_size = size; wr_data = data;
        ok = model_store(off, size, data, 1'b1);
        $display("store off=%h size=%0d data=%h accepted=%0d", off, size, data, ok);
        step;
        wr_en = 1'b0;
    endtask

    // ready_mode: 0 always ready, 1 random, 2 pattern 1,0,0,1,1...
    task automatic send(input logic [7:0] len, input int ready_mode, input bit store_during,
                        input bit with_store, input logic [63:0] s_off, input logic [1:0] s_size,
                        input logic [63:0] s_data, input int abort_after);
        int L, B, hs, cyc;
        beat_t b;
        tx_start = 1'b1;
        tx_len = len;
        if (with_store) begin
            wr_en = 1'b1; wr_off = s_off; wr_size = s_size; wr_data = s_data;
            void'(model_store(s_off, s_size, s_data, 1'b1));
        end
        L = (len > 128) ? 128 : int'(len);
        B = (L + 7) / 8;
        for (int k = 0; k < B; k++) begin
            for (int j = 0; j < 8; j++) b.data[8*j +: 8] = model[8*k + j];
            b.last = (k == B - 1);
            b.keep = (b.last && (L % 8 != 0)) ? 8'((1 << (L % 8)) - 1) : 8'hFF;
            exp_q.push_back(b);
        end
        if (abort_after < 0) done_q.push_back(1'b1);
        step;
        tx_start = 1'b0;
        wr_en = 1'b0;
        check("valid_latency", tx_valid, (L > 0));
        check("busy_latency", busy, (L > 0));
        if (L == 0) begin
            check("done_len0", tx_done, 1);
            $display("send len=%0d beats=0", len);
            return;
        end
        hs = 0;
        cyc = 0;
        while (hs < B && cyc < 600) begin
            if (abort_after >= 0 && hs == abort_after) begin
                tx_ready = 1'b0;
                rst = 1'b1;
                step;
                model_clear();
                check("abort_valid", tx_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", tx_done, 0);
                rst = 1'b0;
                for (int i = 0; i < 4; i++) step;
                $display("send len=%0d aborted after %0d beats", len, hs);
                return;
            end
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = !(cyc == 1 || cyc == 2);
            endcase
            if (store_during && (cyc % 2 == 0)) begin
                wr_en = 1'b1; wr_off = 64'd0; wr_size = 2'd2; wr_data = 64'hDEADBEEF;
                void'(model_store(64'd0, 2'd2, 64'hDEADBEEF, 1'b0));
            end
            @(negedge clk);
            if (tx_valid && tx_ready) hs++;
            step;
            wr_en = 1'b0;
            cyc++;
        end
        if (hs < B) begin
            check("send_timeout_beats", hs, B);
            return;
        end
        check("done_pulse", tx_done, 1);
        check("valid_drop", tx_valid, 0);
        check("busy_drop", busy, 0);
        tx_ready = 1'b0;
        $display("send len=%0d beats=%0d cycles=%0d", len, B, cyc);
    endtask

    function automatic logic [63:0] rand_off;
        if ($urandom_range(0, 9) == 0) return {32'hFFFF_FFFF, 32'($urandom)};
        return 64'($urandom_range(0, 130));
    endfunction

    initial begin
        #1;
        step;
        do_reset();
        // 1: basic two-beat packet
        store(64'd0, 2'd3, 64'h0807060504030201);
        store(64'd8, 2'd0, 64'hAA);
        send(8'd9, 0, 0, 0, 0, 0, 0, -1);
        // 2: stalled last beat
        send(8'd13, 2, 0, 0, 0, 0, 0, -1);
        // 3: out-of-range stores rejected
        do_reset();
        store(64'd121, 2'd3, 64'h1122334455667788);
        store(64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 64'hBEEF);
        send(8'd128, 0, 0, 0, 0, 0, 0, -1);
        // 4: stores during SEND rejected
        store(64'd0, 2'd3, 64'h0123456789ABCDEF);
        send(8'd16, 1, 1, 0, 0, 0, 0, -1);
        send(8'd8, 0, 0, 0, 0, 0, 0, -1);
        // 5: zero and oversize lengths, plus store with start and back-to-back
        send(8'd0, 0, 0, 0, 0, 0, 0, -1);
        send(8'd200, 0, 0, 1, 64'd127, 2'd0, 64'h5A, -1);
        // 6: reset mid-send
        send(8'd128, 0, 0, 0, 0, 0, 0, 4);
        send(8'd128, 1, 0, 0, 0, 0, 0, -1);
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 5)
                store(rand_off(), 2'($urandom_range(0, 3)), {$urandom, $urandom});
            else
                send(8'($urandom_range(0, 255)), 1, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), rand_off(), 2'($urandom_range(0, 3)),
                     {$urandom, $urandom}, -1);
            if ($urandom_range(0, 3) == 0) step;
        end
        step;
        step;
        check("beats_outstanding", exp_q.size(), 0);
        check("errs_outstanding", err_q.size(), 0);
        check("dones_outstanding", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
